// File: rtl/out_port_arbiter.sv
// Purpose: round-robin arbiter sharing one output FIFO/link among NUM_REQ routing units, with a burst cap.
// Latency: 1 clk from an accepted request to the registered FIFO write strobe and packet.
// Backpressure: in_full to every requester rises when the FIFO is full, or nearly full with a write in flight.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   in_req          per-requester request, sampled against the current grant
//   in_packet       requester i's packet at bits [i*DATA_W +: DATA_W]
//   in_full         per-requester "may not request"; built only from registered state and FIFO flags
//   out_full        output FIFO has no free slot
//   out_afull       output FIFO has exactly one free slot
//   out_wr_en       registered write strobe into the output FIFO
//   out_packet      registered packet that goes with out_wr_en (holds when idle)
//   out_src         registered index of the requester that sourced out_packet
//   proto_err       sticky flag: a requester raised in_req while its in_full was high
module out_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_req,
  input  logic [NUM_REQ*DATA_W-1:0] in_packet,
  output logic [NUM_REQ-1:0]        in_full,
  input  logic                      out_full,
  input  logic                      out_afull,
  output logic                      out_wr_en,
  output logic [DATA_W-1:0]         out_packet,
  output logic [SRC_W-1:0]          out_src,
  output logic                      proto_err
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;
  localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);

  // Registered state
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               out_wr_en_q, out_wr_en_d;
  logic [DATA_W-1:0]  out_packet_q, out_packet_d;
  logic [SRC_W-1:0]   out_src_q, out_src_d;
  logic               proto_err_q, proto_err_d;

  // Combinational helpers
  logic               blocked;
  logic               holder_req;
  logic               accept;
  logic               last_beat;
  logic               rotate;
  logic [SRC_W-1:0]   sel;
  logic [DATA_W-1:0]  pkt_sel;
  logic [NUM_REQ-1:0] gnt_rot;

  // A write already in flight will consume the last free slot, so treat
  // "almost full with a write landing" the same as full.
  assign blocked = out_full | (out_wr_en_q & out_afull);

  // Only the grant holder may request, and nobody may while blocked.
  // in_req is deliberately absent here so the routing units' combinational
  // req path cannot loop back through this output.
  assign in_full = ~gnt_q | {NUM_REQ{blocked}};

  assign holder_req = |(in_req & gnt_q);
  assign accept     = holder_req & ~blocked;
  assign last_beat  = (burst_q == BURST_LAST);

  // An idle holder gives up its turn even while blocked; a requesting holder
  // keeps its turn through a blocked period and only loses it at the burst cap.
  assign rotate = ~holder_req | (accept & last_beat);

  // One-hot grant to index, and one-hot AND-OR packet mux.
  always_comb begin
    sel     = '0;
    pkt_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        sel = SRC_W'(i);
      end
      pkt_sel = pkt_sel | (in_packet[i*DATA_W +: DATA_W] & {DATA_W{gnt_q[i]}});
    end
  end

  // Rotate-left by one: grant moves from index i to (i+1) mod NUM_REQ.
  always_comb begin
    gnt_rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt_rot[(i + 1) % NUM_REQ] = gnt_q[i];
    end
  end

  always_comb begin
    gnt_d        = gnt_q;
    burst_d      = burst_q;
    out_wr_en_d  = accept;
    out_packet_d = out_packet_q;
    out_src_d    = out_src_q;
    proto_err_d  = proto_err_q | (|(in_req & in_full));

    if (rotate) begin
      gnt_d   = gnt_rot;
      burst_d = '0;
    end else if (accept) begin
      burst_d = burst_q + BURST_W'(1);
    end

    if (accept) begin
      out_packet_d = pkt_sel;
      out_src_d    = sel;
    end
  end

  // Reset drops whatever was being accepted this cycle; the routing units
  // still hold their packets and will request again.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q        <= NUM_REQ'(1);
      burst_q      <= '0;
      out_wr_en_q  <= 1'b0;
      out_packet_q <= '0;
      out_src_q    <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      gnt_q        <= gnt_d;
      burst_q      <= burst_d;
      out_wr_en_q  <= out_wr_en_d;
      out_packet_q <= out_packet_d;
      out_src_q    <= out_src_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign out_wr_en  = out_wr_en_q;
  assign out_packet = out_packet_q;
  assign out_src    = out_src_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_out_port_arbiter.sv
// Purpose: directed bench for out_port_arbiter with a write scoreboard.
// Latency: expected writes are queued when stimulus is driven and popped on out_wr_en.
// Backpressure: out_full/out_afull are driven directly to exercise blocking.
module tb_out_port_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_W    = 64;
  localparam int MAX_BURST = 4;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        in_req;
  logic [NUM_REQ*DATA_W-1:0] in_packet;
  logic [NUM_REQ-1:0]        in_full;
  logic                      out_full;
  logic                      out_afull;
  logic                      out_wr_en;
  logic [DATA_W-1:0]         out_packet;
  logic [1:0]                out_src;
  logic                      proto_err;

  always #5 clk = ~clk;

  out_port_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_req    (in_req),
    .in_packet (in_packet),
    .in_full   (in_full),
    .out_full  (out_full),
    .out_afull (out_afull),
    .out_wr_en (out_wr_en),
    .out_packet(out_packet),
    .out_src   (out_src),
    .proto_err (proto_err)
  );

  typedef struct {
    logic [63:0] pkt;
    logic [1:0]  src;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [63:0] p, input logic [1:0] s);
    exp_t e;
    e.pkt = p;
    e.src = s;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int i, input logic [63:0] v);
    in_packet[i*DATA_W +: DATA_W] = v;
  endtask

  function automatic logic [63:0] pk3(input int i);
    return 64'hC0DE_0000_0000_00F0 + 64'(i);
  endfunction

  // Two reset cycles; checks the reset-state outputs in the first one.
  task automatic do_reset();
    reset     = 1'b1;
    in_req    = '0;
    out_full  = 1'b0;
    out_afull = 1'b0;
    tick();
    @(negedge clk);
    check("rst_in_full",    64'(in_full),    64'(4'b1110));
    check("rst_wr_en",      64'(out_wr_en),  64'd0);
    check("rst_proto_err",  64'(proto_err),  64'd0);
    check("rst_out_packet", out_packet,      64'd0);
    check("rst_out_src",    64'(out_src),    64'd0);
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every FIFO write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_wr_en) begin
      exp_t e;
      check("sb_write_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("sb_packet", out_packet,   e.pkt);
        check("sb_src",    64'(out_src), 64'(e.src));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=still_running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_full;
    bit         exp_wr2 [8];

    reset     = 1'b1;
    in_req    = '0;
    in_packet = '0;
    out_full  = 1'b0;
    out_afull = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_pkt(i, 64'h0123_4567_0000_0000 + 64'(i));

    // Idle: grant walks 0,1,2,3,0 one step per clock.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_full = ~(4'b0001 << i);
      check("t1_in_full", 64'(in_full),   64'(exp_full));
      check("t1_wr_en",   64'(out_wr_en), 64'd0);
      tick();
    end
    // Back at requester 0: start a steady single requester.
    in_req = 4'b0001;
    set_pkt(0, 64'hA5);
    for (int k = 0; k < 5; k++) push(64'hA5, 2'd0);
    @(negedge clk);
    check("t1_in_full_wrap", 64'(in_full), 64'(4'b1110));

    // Four writes, three dead clocks, then requester 0 again.
    exp_wr2 = '{1, 1, 1, 1, 0, 0, 0, 1};
    for (int j = 0; j < 8; j++) begin
      tick();
      if (j == 7) in_req = '0;
      @(negedge clk);
      check("t2_wr_en", 64'(out_wr_en), 64'(exp_wr2[j]));
      if (j == 3) check("t2_proto_before", 64'(proto_err), 64'd0);
      if (j == 4) check("t2_proto_after",  64'(proto_err), 64'd1);
    end

    // All four requesting: 4 beats per source, no dead cycles.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_pkt(i, pk3(i));
    in_req = 4'b1111;
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 4; b++) push(pk3(r % 4), 2'(r % 4));
    for (int j = 1; j <= 20; j++) begin
      tick();
      if (j == 20) in_req = '0;
      @(negedge clk);
      check("t3_wr_en", 64'(out_wr_en), 64'd1);
      exp_full = ~(4'b0001 << ((j / 4) % 4));
      check("t3_in_full", 64'(in_full), 64'(exp_full));
    end

    // Almost-full with a write in flight, then full: grant held throughout.
    do_reset();
    in_req = 4'b0001;
    set_pkt(0, 64'hBEEF_0004);
    push(64'hBEEF_0004, 2'd0);
    tick();
    out_afull = 1'b1;
    @(negedge clk);
    check("t4_wr_inflight", 64'(out_wr_en), 64'd1);
    check("t4_full_afull",  64'(in_full),   64'(4'b1111));
    tick();
    push(64'hBEEF_0004, 2'd0);
    @(negedge clk);
    check("t4_wr_blocked",  64'(out_wr_en), 64'd0);
    check("t4_gnt_held",    64'(in_full),   64'(4'b1110));
    tick();
    out_full  = 1'b1;
    out_afull = 1'b0;
    @(negedge clk);
    check("t4_wr_second",   64'(out_wr_en), 64'd1);
    check("t4_full_full",   64'(in_full),   64'(4'b1111));
    tick();
    out_full = 1'b0;
    push(64'hBEEF_0004, 2'd0);
    @(negedge clk);
    check("t4_wr_fullwins", 64'(out_wr_en), 64'd0);
    check("t4_gnt_held2",   64'(in_full),   64'(4'b1110));
    tick();
    in_req = '0;
    @(negedge clk);
    check("t4_wr_third",    64'(out_wr_en), 64'd1);
    tick();
    @(negedge clk);
    check("t4_wr_idle",     64'(out_wr_en), 64'd0);

    // Non-granted request: no write, sticky proto_err.
    do_reset();
    set_pkt(2, 64'h5EED_0002);
    in_req = 4'b0100;
    @(negedge clk);
    check("t5_proto_before", 64'(proto_err), 64'd0);
    tick();
    in_req = '0;
    @(negedge clk);
    check("t5_proto_set",  64'(proto_err), 64'd1);
    check("t5_no_write",   64'(out_wr_en), 64'd0);
    for (int j = 0; j < 3; j++) begin
      tick();
      @(negedge clk);
      check("t5_proto_sticky", 64'(proto_err), 64'd1);
      check("t5_no_write",     64'(out_wr_en), 64'd0);
    end

    // Reset in the middle of a burst (burst count 2).
    do_reset();
    in_req = 4'b0001;
    set_pkt(0, 64'hB6B6);
    push(64'hB6B6, 2'd0);
    push(64'hB6B6, 2'd0);
    tick();
    @(negedge clk);
    check("t6_wr_1", 64'(out_wr_en), 64'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("t6_wr_2", 64'(out_wr_en), 64'd1);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) push(64'hB6B6, 2'd0);
    @(negedge clk);
    check("t6_wr_dropped", 64'(out_wr_en), 64'd0);
    check("t6_gnt_reset",  64'(in_full),   64'(4'b1110));
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge clk);
      check("t6_full_burst", 64'(out_wr_en), 64'd1);
    end
    tick();
    in_req = '0;
    @(negedge clk);
    check("t6_burst_end", 64'(out_wr_en), 64'd0);

    tick();
    tick();
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
